// File: rtl/reduction_result_collector_pkg.sv
// collector_pkg: shared definitions for reduction_result_collector.
//   MODE_MAC / MODE_OUTER : mode encodings
//   state_t               : MAC accumulation FSM states
//   rescale_sat           : fixed-point rescale (optional rounding) plus saturation
package collector_pkg;

  localparam logic [2:0] MODE_MAC   = 3'b000;
  localparam logic [2:0] MODE_OUTER = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_POST  = 2'd2
  } state_t;

  // Operates on a 64-bit sign-extended value so that one helper serves every
  // accumulator width. The caller truncates to data_width; the clamp ensures
  // that truncation is lossless.
  function automatic logic signed [63:0] rescale_sat(
    input logic signed [63:0] val,
    input int                 frac_bits,
    input int                 data_width,
    input bit                 round_en
  );
    logic signed [63:0] biased;
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    biased = val;
    if (round_en && frac_bits > 0) biased = val + (64'sd1 <<< (frac_bits - 1));
    shifted = biased >>> frac_bits;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (shifted > hi)      rescale_sat = hi;
    else if (shifted < lo) rescale_sat = lo;
    else                   rescale_sat = shifted;
  endfunction

endpackage

// File: rtl/reduction_result_collector_if.sv
// reduction_result_collector_if: input partial-vector stream plus output
// valid/ready result port.
//   valid_reduced, reduced_vec       : upstream beats (no backpressure)
//   out_valid, out_ready             : result handshake
//   out_vec, out_tag                 : FIFO head data and sequence tag
// Modports: slave = collector side, master = producer/consumer side.
interface reduction_result_collector_if #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int TAG_WIDTH  = 16
);
  logic                                       valid_reduced;
  logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] reduced_vec;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]       out_vec;
  logic [TAG_WIDTH-1:0]                       out_tag;

  modport slave (
    input  valid_reduced, reduced_vec, out_ready,
    output out_valid, out_vec, out_tag
  );

  modport master (
    output valid_reduced, reduced_vec, out_ready,
    input  out_valid, out_vec, out_tag
  );
endinterface

// File: rtl/reduction_result_collector_result_fifo.sv
// result_fifo: synchronous FIFO holding finished result entries.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush
//   push, din  : write request/data (accepted when not full, or full with a pop)
//   pop        : read request (ignored when empty)
//   dout       : head entry, zero while empty
//   full/empty : status flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module result_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reduction_result_collector.sv
// reduction_result_collector: accumulates K_BLOCKS partial vectors per row
// block (MAC mode) or passes each vector through (OUTER mode), rescales and
// saturates every result, and queues it with a sequence tag in result_fifo.
//   clk, rst_n   : clock, async active-low reset
//   clear        : sync clear of accumulator, counters, FIFO, overflow_err
//   mode         : 000 MAC, 011 OUTER, others drop beats and flag mode_err
//   bus (slave)  : reduced_vec stream in, valid/ready result port out
//   busy         : high in ACCUM and POST
//   overflow_err : sticky, a result was dropped at a full FIFO
//   mode_err     : sticky, a beat arrived in an unsupported mode
// Build option: define COLLECTOR_ROUND_EN to round half toward +inf before
// the shift; otherwise results are floored.
//
// state   | meaning
// S_IDLE  | no block open; OUTER beats pass through here
// S_ACCUM | summing MAC beats, rem = beats still missing
// S_POST  | full block in acc, pushed this cycle
module reduction_result_collector
  import collector_pkg::*;
#(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int K_BLOCKS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [2:0]                    mode,
  reduction_result_collector_if.slave   bus,
  output logic                          busy,
  output logic                          overflow_err,
  output logic                          mode_err
);
  localparam int AW = ACC_WIDTH + $clog2(K_BLOCKS);
  localparam int CW = $clog2(K_BLOCKS + 1);
  localparam int VW = TILE_SIZE * DATA_WIDTH;
  localparam int EW = VW + TAG_WIDTH;
`ifdef COLLECTOR_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t                         state, state_nxt;
  logic [CW-1:0]                  rem, rem_nxt;
  logic                           acc_load, acc_add, post_push;
  logic signed [AW-1:0]           acc [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0]    outer_q [TILE_SIZE];
  logic                           outer_v;
  logic [TAG_WIDTH-1:0]           tag;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] push_lanes;
  logic                           push_req, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]                  fifo_dout;

  wire mac_beat   = bus.valid_reduced && (mode == MODE_MAC);
  wire outer_beat = bus.valid_reduced && (mode == MODE_OUTER);
  wire bad_beat   = bus.valid_reduced && !(mode == MODE_MAC || mode == MODE_OUTER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rem   <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    post_push = 1'b0;
    case (state)
      S_IDLE, S_POST: begin
        post_push = (state == S_POST);
        // A MAC beat in POST opens the next block so back-to-back blocks lose nothing.
        if (mac_beat) begin
          acc_load  = 1'b1;
          rem_nxt   = CW'(K_BLOCKS - 1);
          state_nxt = (K_BLOCKS == 1) ? S_POST : S_ACCUM;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (mode != MODE_MAC) begin
          state_nxt = S_IDLE;
        end else if (bus.valid_reduced) begin
          acc_add = 1'b1;
          rem_nxt = rem - CW'(1);
          if (rem == CW'(1)) state_nxt = S_POST;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        acc[i]     <= '0;
        outer_q[i] <= '0;
      end
      outer_v <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        acc[i]     <= '0;
        outer_q[i] <= '0;
      end
      outer_v <= 1'b0;
    end else begin
      outer_v <= outer_beat;
      for (int i = 0; i < TILE_SIZE; i++) begin
        if (acc_load)     acc[i] <= AW'($signed(bus.reduced_vec[i]));
        else if (acc_add) acc[i] <= acc[i] + AW'($signed(bus.reduced_vec[i]));
        if (outer_beat)   outer_q[i] <= $signed(bus.reduced_vec[i]);
      end
    end
  end

  // POST and a pending OUTER beat are never active together, so one
  // rescale path serves both.
  always_comb begin
    for (int i = 0; i < TILE_SIZE; i++) begin
      push_lanes[i] = DATA_WIDTH'(rescale_sat(post_push ? 64'(acc[i]) : 64'(outer_q[i]),
                                              FRAC_BITS, DATA_WIDTH, ROUND_EN));
    end
  end

  assign push_req = post_push || outer_v;
  assign fifo_pop = bus.out_ready && !fifo_empty;

  // The tag advances on every result, including one dropped at a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag          <= '0;
      overflow_err <= 1'b0;
      mode_err     <= 1'b0;
    end else begin
      if (bad_beat) mode_err <= 1'b1;
      if (clear) begin
        tag          <= '0;
        overflow_err <= 1'b0;
      end else if (push_req) begin
        tag <= tag + TAG_WIDTH'(1);
        if (fifo_full && !fifo_pop) overflow_err <= 1'b1;
      end
    end
  end

  result_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_req),
    .din   ({tag, push_lanes}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_vec   = fifo_dout[VW-1:0];
  assign bus.out_tag   = fifo_dout[EW-1 -: TAG_WIDTH];
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_reduction_result_collector.sv
module tb_reduction_result_collector;
  import collector_pkg::*;

  localparam int TS  = 4;
  localparam int DW  = 16;
  localparam int AWI = 32;
  localparam int TW  = 16;
`ifdef COLLECTOR_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [2:0] mode;
  logic       busy, overflow_err, mode_err;

  always #5 clk = ~clk;

  reduction_result_collector_if #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .ACC_WIDTH(AWI), .TAG_WIDTH(TW)) bus();

  reduction_result_collector #(
    .TILE_SIZE(TS), .DATA_WIDTH(DW), .ACC_WIDTH(AWI), .FRAC_BITS(8),
    .K_BLOCKS(16), .FIFO_DEPTH(4), .TAG_WIDTH(TW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .mode         (mode),
    .bus          (bus),
    .busy         (busy),
    .overflow_err (overflow_err),
    .mode_err     (mode_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int lane_in   [TS];
    int exp_floor [TS];
    int exp_round [TS];
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane(input int i);
    return longint'($signed(bus.out_vec[i]));
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat_all(input logic [2:0] m, input int v);
    mode = m;
    bus.valid_reduced = 1'b1;
    for (int i = 0; i < TS; i++) bus.reduced_vec[i] = v;
    step();
    bus.valid_reduced = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_result(input string name, input longint val, input longint t);
    check({name, "_valid"}, bus.out_valid, 1);
    for (int i = 0; i < TS; i++) check({name, "_lane"}, lane(i), val);
    check({name, "_tag"}, bus.out_tag, t);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out_vec"}, bus.out_vec, 0);
    check({name, "_out_tag"}, bus.out_tag, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_overflow_err"}, overflow_err, 0);
    check({name, "_mode_err"}, mode_err, 0);
  endtask

  int     got_n;
  longint got_val [4];
  longint got_tag [4];

  task automatic sample_out();
    if (bus.out_valid) begin
      if (got_n < 4) begin
        got_val[got_n] = lane(0);
        got_tag[got_n] = bus.out_tag;
      end
      got_n++;
    end
  endtask

  initial begin
    vecs[0].lane_in = '{256, 512, -256, 0};
    vecs[0].exp_floor = '{1, 2, -1, 0};
    vecs[0].exp_round = '{1, 2, -1, 0};
    vecs[1].lane_in = '{-384, 640, 383, -1};
    vecs[1].exp_floor = '{-2, 2, 1, -1};
    vecs[1].exp_round = '{-1, 3, 1, 0};
    vecs[2].lane_in = '{32'h7FFF_FFFF, 32'h8000_0000, 8388352, 8388608};
    vecs[2].exp_floor = '{32767, -32768, 32767, 32767};
    vecs[2].exp_round = '{32767, -32768, 32767, 32767};
    vecs[3].lane_in = '{-8388608, -8388609, 255, -256};
    vecs[3].exp_floor = '{-32768, -32768, 0, -1};
    vecs[3].exp_round = '{-32768, -32768, 1, -1};

    rst_n = 1'b0;
    clear = 1'b0;
    mode = MODE_MAC;
    bus.valid_reduced = 1'b0;
    bus.reduced_vec = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // OUTER pass-through table: rescale, rounding and saturation
    for (int k = 0; k < 4; k++) begin
      mode = MODE_OUTER;
      bus.valid_reduced = 1'b1;
      for (int i = 0; i < TS; i++) bus.reduced_vec[i] = vecs[k].lane_in[i];
      step();
      bus.valid_reduced = 1'b0;
      check("outer_latency_early", bus.out_valid, 0);
      step();
      check("outer_valid", bus.out_valid, 1);
      for (int i = 0; i < TS; i++)
        check("outer_lane", lane(i), RND ? vecs[k].exp_round[i] : vecs[k].exp_floor[i]);
      check("outer_tag", bus.out_tag, k);
    end
    step();
    do_clear();

    // MAC sum
    for (int b = 0; b < 16; b++) begin
      beat_all(MODE_MAC, 256);
      check("mac_busy", busy, 1);
    end
    check("mac_not_yet_valid", bus.out_valid, 0);
    step();
    check_result("mac_sum", 16, 0);
    check("mac_busy_done", busy, 0);
    step();
    check("mac_popped", bus.out_valid, 0);

    // Saturation through the accumulator
    for (int b = 0; b < 16; b++) beat_all(MODE_MAC, 32'h4000_0000);
    step();
    check_result("sat_pos", 32767, 1);
    step();
    for (int b = 0; b < 16; b++) beat_all(MODE_MAC, 32'hC000_0000);
    step();
    check_result("sat_neg", -32768, 2);
    step();

    // Overflow with a stalled consumer
    do_clear();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) beat_all(MODE_OUTER, 256);
    step();
    check("ovf_err", overflow_err, 1);
    check_result("ovf_head", 1, 0);
    step();
    check("ovf_hold_tag", bus.out_tag, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_result("ovf_drain", 1, k);
      step();
    end
    check("ovf_empty", bus.out_valid, 0);
    do_clear();
    check("ovf_cleared", overflow_err, 0);

    // Abort a partial MAC block
    for (int b = 0; b < 7; b++) beat_all(MODE_MAC, 256);
    check("abort_busy_before", busy, 1);
    mode = MODE_OUTER;
    step();
    check("abort_busy_after", busy, 0);
    repeat (2) step();
    check("abort_no_result", bus.out_valid, 0);
    beat_all(MODE_OUTER, 512);
    step();
    check_result("abort_outer", 2, 0);
    step();

    // Unsupported mode
    check("mode_err_initial", mode_err, 0);
    beat_all(3'b101, 256);
    check("mode_err_set", mode_err, 1);
    step();
    check("mode_err_no_push", bus.out_valid, 0);
    do_clear();
    check("mode_err_sticky", mode_err, 1);

    // Back-to-back MAC blocks
    got_n = 0;
    for (int b = 0; b < 32; b++) begin
      beat_all(MODE_MAC, (b < 16) ? 256 : 512);
      sample_out();
    end
    for (int c = 0; c < 4; c++) begin
      step();
      sample_out();
    end
    check("b2b_count", got_n, 2);
    check("b2b_val0", got_val[0], 16);
    check("b2b_tag0", got_tag[0], 0);
    check("b2b_val1", got_val[1], 32);
    check("b2b_tag1", got_tag[1], 1);

    // Async reset mid-block with a queued entry
    bus.out_ready = 1'b0;
    beat_all(MODE_OUTER, 768);
    step();
    check_result("pre_rst_entry", 3, 2);
    for (int b = 0; b < 5; b++) beat_all(MODE_MAC, 256);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_immediate");
    repeat (3) step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check_reset_vals("rst_after");
    beat_all(MODE_OUTER, 256);
    step();
    check_result("post_rst_outer", 1, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
